// File: rtl/print_spooler_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : print_spooler_fifo_if
//  Description : Enqueue handshake and head-peek bundle of the print spooler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface print_spooler_fifo_if #(
    parameter int ID_W    = 8,
    parameter int PAGES_W = 8
);
    logic               enq_valid;
    logic [ID_W-1:0]    enq_id;
    logic [PAGES_W-1:0] enq_pages;
    logic               enq_ready;
    logic               head_valid;
    logic [ID_W-1:0]    head_id;
    logic [PAGES_W-1:0] head_pages;

    modport master (
        output enq_valid, enq_id, enq_pages,
        input  enq_ready, head_valid, head_id, head_pages
    );

    modport slave (
        input  enq_valid, enq_id, enq_pages,
        output enq_ready, head_valid, head_id, head_pages
    );
endinterface
`default_nettype wire

// File: rtl/print_spooler_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : print_spooler_fifo
//  Description : Circular job queue with an automatic page-timed printer engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module print_spooler_fifo #(
    parameter int DEPTH       = 4,
    parameter int ID_W        = 8,
    parameter int PAGES_W     = 8,
    parameter int PAGE_CYCLES = 4,
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int TOT_W      = PAGES_W + CNT_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    print_spooler_fifo_if.slave      bus,
    input  wire logic                flush,
    input  wire logic                pause,
    input  wire logic                clr_err,
    output logic [CNT_W-1:0]         count,
    output logic [TOT_W-1:0]         total_pages,
    output logic                     empty,
    output logic                     full,
    output logic                     printing,
    output logic [ID_W-1:0]          print_id,
    output logic [PAGES_W-1:0]       pages_left,
    output logic                     job_done,
    output logic [ID_W-1:0]          done_id,
    output logic                     err_overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CYC_W = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRINT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [ID_W-1:0]    mem_id_q    [DEPTH];
    logic [PAGES_W-1:0] mem_pages_q [DEPTH];

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TOT_W-1:0]   total_q, total_d;
    logic               empty_q, empty_d, full_q, full_d, err_q, err_d;
    logic [1:0]         state_q, state_d;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [ID_W-1:0]    print_id_q, print_id_d;
    logic [PAGES_W-1:0] pages_left_q, pages_left_d;

    logic               w_do_enq, w_do_pop;
    logic [ID_W-1:0]    w_head_id;
    logic [PAGES_W-1:0] w_head_pages;

    assign w_head_id    = empty_q ? '0 : mem_id_q[rd_ptr_q];
    assign w_head_pages = empty_q ? '0 : mem_pages_q[rd_ptr_q];

    // enq_ready looks only at pre-edge fullness, so a pop cannot free a slot for a same-edge enqueue
    assign w_do_enq = bus.enq_valid && !full_q && !flush;
    assign w_do_pop = (state_q == ST_IDLE) && !empty_q && !pause && !flush;

    assign bus.enq_ready  = !full_q;
    assign bus.head_valid = !empty_q;
    assign bus.head_id    = w_head_id;
    assign bus.head_pages = w_head_pages;

    assign count        = count_q;
    assign total_pages  = total_q;
    assign empty        = empty_q;
    assign full         = full_q;
    assign print_id     = print_id_q;
    assign pages_left   = pages_left_q;
    assign err_overflow = err_q;

    always_ff @(posedge clk) begin
        if (w_do_enq) begin
            mem_id_q[wr_ptr_q]    <= bus.enq_id;
            mem_pages_q[wr_ptr_q] <= bus.enq_pages;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        total_d  = total_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            total_d  = '0;
        end else begin
            if (w_do_enq) wr_ptr_d = wr_ptr_q + 1'b1;
            if (w_do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CNT_W'(w_do_enq) - CNT_W'(w_do_pop);
            total_d = total_q
                    + (w_do_enq ? TOT_W'(bus.enq_pages) : '0)
                    - (w_do_pop ? TOT_W'(w_head_pages)  : '0);
        end
        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_W'(DEPTH));
        err_d   = (bus.enq_valid && full_q) ? 1'b1 : (clr_err ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            total_q      <= '0;
            empty_q      <= 1'b1;
            full_q       <= 1'b0;
            err_q        <= 1'b0;
            state_q      <= ST_IDLE;
            cyc_q        <= '0;
            print_id_q   <= '0;
            pages_left_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            total_q      <= total_d;
            empty_q      <= empty_d;
            full_q       <= full_d;
            err_q        <= err_d;
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            print_id_q   <= print_id_d;
            pages_left_q <= pages_left_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        print_id_d   = print_id_q;
        pages_left_d = pages_left_q;
        case (state_q)
            ST_IDLE: begin
                if (w_do_pop) begin
                    print_id_d   = w_head_id;
                    pages_left_d = w_head_pages;
                    cyc_d        = '0;
                    state_d      = (w_head_pages == '0) ? ST_DONE : ST_PRINT;
                end
            end
            ST_PRINT: begin
                if (!pause) begin
                    if (cyc_q == CYC_W'(PAGE_CYCLES - 1)) begin
                        cyc_d        = '0;
                        pages_left_d = pages_left_q - 1'b1;
                        if (pages_left_q == PAGES_W'(1)) state_d = ST_DONE;
                    end else begin
                        cyc_d = cyc_q + 1'b1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        printing = (state_q == ST_PRINT) || (state_q == ST_DONE);
        job_done = (state_q == ST_DONE);
        done_id  = job_done ? print_id_q : '0;
    end

endmodule
`default_nettype wire

// File: tb/tb_print_spooler_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_print_spooler_fifo
//  Description : Directed self-checking bench for the print spooler queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_print_spooler_fifo;

    localparam int DEPTH       = 4;
    localparam int ID_W        = 8;
    localparam int PAGES_W     = 8;
    localparam int PAGE_CYCLES = 4;
    localparam int CNT_W       = $clog2(DEPTH + 1);
    localparam int TOT_W       = PAGES_W + CNT_W;

    logic               clk;
    logic               rst_n;
    logic               flush, pause, clr_err;
    logic [CNT_W-1:0]   count;
    logic [TOT_W-1:0]   total_pages;
    logic               empty, full, printing, job_done, err_overflow;
    logic [ID_W-1:0]    print_id, done_id;
    logic [PAGES_W-1:0] pages_left;

    int n_checks = 0;
    int n_fail   = 0;

    print_spooler_fifo_if #(.ID_W(ID_W), .PAGES_W(PAGES_W)) bus ();

    print_spooler_fifo #(
        .DEPTH(DEPTH), .ID_W(ID_W), .PAGES_W(PAGES_W), .PAGE_CYCLES(PAGE_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .flush(flush), .pause(pause), .clr_err(clr_err),
        .count(count), .total_pages(total_pages), .empty(empty), .full(full),
        .printing(printing), .print_id(print_id), .pages_left(pages_left),
        .job_done(job_done), .done_id(done_id), .err_overflow(err_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic enq(input logic [ID_W-1:0] id, input logic [PAGES_W-1:0] pg);
        bus.enq_valid = 1'b1;
        bus.enq_id    = id;
        bus.enq_pages = pg;
        tick();
        bus.enq_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; pause = 1'b0; clr_err = 1'b0;
        bus.enq_valid = 1'b0; bus.enq_id = '0; bus.enq_pages = '0;
        ticks(2);
        check_eq("rst_count", count, 0);
        check_eq("rst_total", total_pages, 0);
        check_eq("rst_empty", empty, 1);
        check_eq("rst_full", full, 0);
        check_eq("rst_ready", bus.enq_ready, 1);
        check_eq("rst_head_valid", bus.head_valid, 0);
        check_eq("rst_printing", printing, 0);
        check_eq("rst_job_done", job_done, 0);
        check_eq("rst_err", err_overflow, 0);
        rst_n = 1'b1;
        tick();

        // fill while paused
        pause = 1'b1;
        enq(8'd1, 8'd12); enq(8'd2, 8'd25); enq(8'd3, 8'd7);
        check_eq("fill_count", count, 3);
        check_eq("fill_total", total_pages, 44);
        check_eq("fill_head_id", bus.head_id, 1);
        check_eq("fill_head_pages", bus.head_pages, 12);
        check_eq("fill_empty", empty, 0);
        check_eq("fill_printing", printing, 0);

        enq(8'd4, 8'd5);
        check_eq("full_flag", full, 1);
        check_eq("full_ready", bus.enq_ready, 0);
        enq(8'd5, 8'd9);
        check_eq("ovf_count", count, 4);
        check_eq("ovf_total", total_pages, 49);
        check_eq("ovf_err", err_overflow, 1);
        bus.enq_valid = 1'b1; clr_err = 1'b1;
        tick();
        bus.enq_valid = 1'b0;
        check_eq("ovf_set_wins", err_overflow, 1);
        tick();
        clr_err = 1'b0;
        check_eq("ovf_cleared", err_overflow, 0);

        flush = 1'b1; tick(); flush = 1'b0;
        check_eq("flush_count", count, 0);
        check_eq("flush_total", total_pages, 0);
        check_eq("flush_head_id", bus.head_id, 0);

        // single 2-page job
        enq(8'd1, 8'd2);
        pause = 1'b0;
        tick();
        check_eq("j1_printing", printing, 1);
        check_eq("j1_print_id", print_id, 1);
        check_eq("j1_pages_e0", pages_left, 2);
        check_eq("j1_count", count, 0);
        ticks(4); check_eq("j1_pages_e4", pages_left, 1);
        ticks(3); check_eq("j1_done_e7", job_done, 0);
        tick();
        check_eq("j1_pages_e8", pages_left, 0);
        check_eq("j1_done", job_done, 1);
        check_eq("j1_done_id", done_id, 1);
        tick();
        check_eq("j1_idle_printing", printing, 0);
        check_eq("j1_idle_done", job_done, 0);

        // zero-page job followed by a one-page job
        pause = 1'b1;
        enq(8'd7, 8'd0); enq(8'd8, 8'd1);
        pause = 1'b0;
        tick();
        check_eq("j7_done", job_done, 1);
        check_eq("j7_done_id", done_id, 7);
        tick();
        check_eq("j7_idle", printing, 0);
        tick();
        check_eq("j8_print_id", print_id, 8);
        check_eq("j8_count", count, 0);
        ticks(3); check_eq("j8_not_done", job_done, 0);
        tick();
        check_eq("j8_done", job_done, 1);
        check_eq("j8_done_id", done_id, 8);
        tick();

        // pause mid-print for 5 cycles
        pause = 1'b1;
        enq(8'd10, 8'd2);
        pause = 1'b0;
        tick();
        ticks(2);
        pause = 1'b1;
        ticks(5);
        check_eq("pz_frozen_pages", pages_left, 2);
        check_eq("pz_printing", printing, 1);
        pause = 1'b0;
        tick(); check_eq("pz_e8_pages", pages_left, 2);
        tick(); check_eq("pz_e9_pages", pages_left, 1);
        ticks(3); check_eq("pz_e12_done", job_done, 0);
        tick();
        check_eq("pz_e13_done", job_done, 1);
        check_eq("pz_done_id", done_id, 10);
        tick();

        // flush while printing
        pause = 1'b1;
        enq(8'd11, 8'd1); enq(8'd12, 8'd3); enq(8'd13, 8'd4);
        pause = 1'b0;
        tick();
        check_eq("fp_count", count, 2);
        check_eq("fp_total", total_pages, 7);
        flush = 1'b1; tick(); flush = 1'b0;
        check_eq("fp_flush_count", count, 0);
        check_eq("fp_flush_total", total_pages, 0);
        check_eq("fp_still_printing", print_id, 11);
        ticks(3);
        check_eq("fp_done", job_done, 1);
        check_eq("fp_done_id", done_id, 11);
        ticks(2);
        check_eq("fp_idle", printing, 0);
        check_eq("fp_empty", empty, 1);

        // enqueue on the pop edge
        pause = 1'b1;
        enq(8'd2, 8'd25); enq(8'd3, 8'd7);
        check_eq("sim_pre_total", total_pages, 32);
        pause = 1'b0;
        enq(8'd9, 8'd6);
        check_eq("sim_count", count, 2);
        check_eq("sim_total", total_pages, 13);
        check_eq("sim_print_id", print_id, 2);
        check_eq("sim_head_id", bus.head_id, 3);

        // asynchronous reset mid-print
        ticks(3);
        rst_n = 1'b0;
        #1;
        check_eq("ar_printing", printing, 0);
        check_eq("ar_count", count, 0);
        check_eq("ar_total", total_pages, 0);
        check_eq("ar_pages_left", pages_left, 0);
        check_eq("ar_print_id", print_id, 0);
        check_eq("ar_job_done", job_done, 0);
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        check_eq("ar_after_done", job_done, 0);
        check_eq("ar_after_printing", printing, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
